t03_sprite_frame_loader: RTL and testbench

Loads sprite bitmaps from a word-wide sprite memory into the 2400-bit, 15×20×8bpp `player` bus that the player display blocks consume, and also supplies their `x`/`y` position. The bitmap and position are double-buffered. A new bitmap is fetched during vertical blanking and swapped in atomically, so no frame ever shows a half-loaded sprite or a position change mid-frame. The block sits between the game-state logic (which picks the sprite frame and position) and the display pipeline.

---
 rtl/t03_sprite_frame_loader.sv | 186 ++++++++++++++++++
 tb/tb_t03_sprite_frame_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/t03_sprite_frame_loader.sv
// Double-buffered sprite bitmap/position loader: fetches 75 words during vblank, swaps atomically in blanking.
// Optional fetch timeout with abort/load_err when T03_LOADER_TIMEOUT_EN is defined.
module t03_sprite_frame_loader #(
  parameter int          V_ACTIVE    = 600,
  parameter int          V_LOAD_LINE = 601,
  parameter logic [15:0] BASE_ADDR   = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   Vcnt,
  input  logic [3:0]    sprite_id,
  input  logic [10:0]   x_in,
  input  logic [10:0]   y_in,
  input  logic          force_reload,
  output logic          mem_req,
  output logic [15:0]   mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic [2399:0] player,
  output logic [10:0]   x,
  output logic [10:0]   y,
  output logic          busy,
  output logic          frame_swapped,
  output logic          load_err
);

  localparam int WORDS = 75;

`ifdef T03_LOADER_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SWAP_WAIT, S_ABORT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SWAP_WAIT} state_t;
`endif

  state_t          state_q, state_d;
  logic [10:0]     vcnt_q;
  logic [10:0]     pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [3:0]      id_l_q, id_l_d;
  logic            fetched_q, fetched_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [2399:0]   shadow_q, shadow_d;
  logic [2399:0]   player_q, player_d;
  logic [10:0]     x_q, x_d, y_q, y_d;
  logic [3:0]      active_id_q, active_id_d;
  logic            active_valid_q, active_valid_d;
  logic            frame_swapped_q, frame_swapped_d;
`ifdef T03_LOADER_TIMEOUT_EN
  logic [7:0]      stall_q, stall_d;
`endif

  logic            trigger;
  logic            in_blank;
  logic [15:0]     word_addr;

  assign trigger   = (Vcnt == 11'(V_LOAD_LINE)) && (vcnt_q != 11'(V_LOAD_LINE));
  assign in_blank  = (Vcnt >= 11'(V_ACTIVE));
  assign word_addr = BASE_ADDR + ({12'd0, id_l_q} * 16'd75) + {9'd0, cnt_q};

  always_comb begin
    state_d         = state_q;
    pend_x_d        = pend_x_q;
    pend_y_d        = pend_y_q;
    id_l_d          = id_l_q;
    fetched_d       = fetched_q;
    cnt_d           = cnt_q;
    shadow_d        = shadow_q;
    player_d        = player_q;
    x_d             = x_q;
    y_d             = y_q;
    active_id_d     = active_id_q;
    active_valid_d  = active_valid_q;
    frame_swapped_d = 1'b0;
`ifdef T03_LOADER_TIMEOUT_EN
    stall_d         = stall_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          pend_x_d = x_in;
          pend_y_d = y_in;
          id_l_d   = sprite_id;
          if (!active_valid_q || (sprite_id != active_id_q) || force_reload) begin
            cnt_d     = '0;
            fetched_d = 1'b1;
            state_d   = S_FETCH;
`ifdef T03_LOADER_TIMEOUT_EN
            stall_d   = '0;
`endif
          end else begin
            fetched_d = 1'b0;
            state_d   = S_SWAP_WAIT;
          end
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          shadow_d = {shadow_q[2367:0], mem_rdata};
          cnt_d    = cnt_q + 7'd1;
`ifdef T03_LOADER_TIMEOUT_EN
          stall_d  = '0;
`endif
          if (cnt_q == 7'(WORDS - 1)) state_d = S_SWAP_WAIT;
        end
`ifdef T03_LOADER_TIMEOUT_EN
        else begin
          // 255th consecutive stalled cycle gives up on this load
          stall_d = stall_q + 8'd1;
          if (stall_q == 8'd254) state_d = S_ABORT;
        end
`endif
      end
      S_SWAP_WAIT: begin
        if (in_blank) begin
          x_d = pend_x_q;
          y_d = pend_y_q;
          if (fetched_q) begin
            player_d       = shadow_q;
            active_id_d    = id_l_q;
            active_valid_d = 1'b1;
          end
          frame_swapped_d = 1'b1;
          state_d         = S_IDLE;
        end
      end
`ifdef T03_LOADER_TIMEOUT_EN
      S_ABORT: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      vcnt_q          <= '0;
      pend_x_q        <= '0;
      pend_y_q        <= '0;
      id_l_q          <= '0;
      fetched_q       <= 1'b0;
      cnt_q           <= '0;
      shadow_q        <= '0;
      player_q        <= '0;
      x_q             <= '0;
      y_q             <= '0;
      active_id_q     <= '0;
      active_valid_q  <= 1'b0;
      frame_swapped_q <= 1'b0;
`ifdef T03_LOADER_TIMEOUT_EN
      stall_q         <= '0;
`endif
    end else begin
      state_q         <= state_d;
      vcnt_q          <= Vcnt;
      pend_x_q        <= pend_x_d;
      pend_y_q        <= pend_y_d;
      id_l_q          <= id_l_d;
      fetched_q       <= fetched_d;
      cnt_q           <= cnt_d;
      shadow_q        <= shadow_d;
      player_q        <= player_d;
      x_q             <= x_d;
      y_q             <= y_d;
      active_id_q     <= active_id_d;
      active_valid_q  <= active_valid_d;
      frame_swapped_q <= frame_swapped_d;
`ifdef T03_LOADER_TIMEOUT_EN
      stall_q         <= stall_d;
`endif
    end
  end

  // Request decoded from the state register so reset drops it without waiting for a clock
  assign mem_req       = (state_q == S_FETCH);
  assign mem_addr      = mem_req ? word_addr : 16'd0;
  assign busy          = (state_q != S_IDLE);
  assign player        = player_q;
  assign x             = x_q;
  assign y             = y_q;
  assign frame_swapped = frame_swapped_q;
`ifdef T03_LOADER_TIMEOUT_EN
  assign load_err      = (state_q == S_ABORT);
`else
  assign load_err      = 1'b0;
`endif

endmodule

// File: tb/tb_t03_sprite_frame_loader.sv
// Directed bench for t03_sprite_frame_loader: memory responder with address scoreboard plus linear test steps.
module tb_t03_sprite_frame_loader;

  logic          clk, rst;
  logic [10:0]   Vcnt;
  logic [3:0]    sprite_id;
  logic [10:0]   x_in, y_in;
  logic          force_reload;
  logic          mem_req;
  logic [15:0]   mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [2399:0] player;
  logic [10:0]   x, y;
  logic          busy, frame_swapped, load_err;

  int checks = 0;
  int errors = 0;
  int ack_mode = 1;          // 0: never ack, 1: ack every cycle, 3: ack every third cycle
  logic [31:0] exp_q[$];     // expected request addresses, in order

  t03_sprite_frame_loader dut (
    .clk(clk), .rst(rst), .Vcnt(Vcnt), .sprite_id(sprite_id), .x_in(x_in), .y_in(y_in),
    .force_reload(force_reload), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .player(player), .x(x), .y(y), .busy(busy),
    .frame_swapped(frame_swapped), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [15:0] a);
    return {a ^ 16'h5A3C, a};
  endfunction

  function automatic logic [2399:0] exp_player(input int id);
    logic [2399:0] p;
    p = '0;
    for (int k = 0; k < 75; k++) p = {p[2367:0], memf(16'(id * 75 + k))};
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves Vcnt at V_LOAD_LINE; the next posedge is the end of the trigger cycle.
  task automatic trigger(input logic [3:0] id, input logic [10:0] xi, input logic [10:0] yi,
                         input logic fr, input logic push);
    Vcnt = 11'd600;
    step(2);
    sprite_id = id; x_in = xi; y_in = yi; force_reload = fr;
    Vcnt = 11'd601;
    if (push) for (int k = 0; k < 75; k++) exp_q.push_back(32'(id * 75 + k));
  endtask

  task automatic wait_swap(input int maxc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxc; i++) begin
      step(1);
      if (frame_swapped) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Memory responder: ack pattern, read data and address scoreboard
  initial begin
    logic [15:0] prev_addr;
    logic        prev_stall;
    logic        a;
    logic [31:0] e;
    int          ph;
    ph = 0; prev_stall = 1'b0; prev_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      ph++;
      if (rst) begin
        mem_ack = 1'b0;
        prev_stall = 1'b0;
      end else begin
        case (ack_mode)
          0:       a = 1'b0;
          1:       a = 1'b1;
          default: a = (ph % 3 == 0);
        endcase
        mem_ack   = a;
        mem_rdata = memf(mem_addr);
        if (prev_stall && mem_req) chk("addr_stable", 64'(mem_addr), 64'(prev_addr));
        if (mem_req && a) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
          chk("addr_order", 64'(mem_addr), 64'(e));
        end
        prev_stall = mem_req && !a;
        prev_addr  = mem_addr;
      end
    end
  end

  initial begin
    int cyc;
    int le;
    logic saw;
    logic [2399:0] sv_player;
    logic [10:0] sv_x, sv_y;

    rst = 1'b1; Vcnt = 11'd600; sprite_id = '0; x_in = '0; y_in = '0; force_reload = 1'b0;
    step(3);
    chk("rst_player", 64'(player === '0), 64'd1);
    chk("rst_x", 64'(x), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_swapped", 64'(frame_swapped), 64'd0);
    chk("rst_load_err", 64'(load_err), 64'd0);
    rst = 1'b0;
    step(2);

    // First load: sprite 2, back-to-back acks
    trigger(4'd2, 11'd100, 11'd50, 1'b0, 1'b1);
    step(1);
    chk("t1_req_rise", 64'(mem_req), 64'd1);
    chk("t1_busy_rise", 64'(busy), 64'd1);
    chk("t1_x_before", 64'(x), 64'd0);
    wait_swap(200, cyc);
    chk("t1_swap_latency", 64'(cyc), 64'd76);
    chk("t1_player", 64'(player === exp_player(2)), 64'd1);
    chk("t1_word0", 64'(player[2399:2368]), 64'(memf(16'd150)));
    chk("t1_word74", 64'(player[31:0]), 64'(memf(16'd224)));
    chk("t1_x", 64'(x), 64'd100);
    chk("t1_y", 64'(y), 64'd50);
    chk("t1_q_empty", 64'(exp_q.size()), 64'd0);
    step(1);
    chk("t1_pulse_single", 64'(frame_swapped), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);

    // Position-only update
    sv_player = player;
    trigger(4'd2, 11'd200, 11'd50, 1'b0, 1'b0);
    step(1);
    chk("t2_no_req", 64'(mem_req), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    chk("t2_x_old", 64'(x), 64'd100);
    step(1);
    chk("t2_x_new", 64'(x), 64'd200);
    chk("t2_swap_pulse", 64'(frame_swapped), 64'd1);
    chk("t2_player_kept", 64'(player === sv_player), 64'd1);

    // Slow memory; swap deferred by active video
    ack_mode = 3;
    trigger(4'd7, 11'd300, 11'd77, 1'b0, 1'b1);
    step(1);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() <= 1) break;
      step(1);
    end
    chk("t3_reach_last", 64'(exp_q.size()), 64'd1);
    Vcnt = 11'd10;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (frame_swapped) saw = 1'b1;
    end
    chk("t3_no_swap_active", 64'(saw), 64'd0);
    chk("t3_waiting", 64'({busy, mem_req}), 64'b10);
    chk("t3_x_held", 64'(x), 64'd200);
    chk("t3_player_held", 64'(player === sv_player), 64'd1);
    Vcnt = 11'd600;
    wait_swap(5, cyc);
    chk("t3_swap_at_blank", 64'(cyc), 64'd1);
    chk("t3_player", 64'(player === exp_player(7)), 64'd1);
    chk("t3_x", 64'(x), 64'd300);
    chk("t3_y", 64'(y), 64'd77);

    // Retrigger while busy is ignored
    ack_mode = 1;
    trigger(4'd3, 11'd400, 11'd40, 1'b0, 1'b1);
    step(10);
    trigger(4'd5, 11'd999, 11'd999, 1'b1, 1'b0);
    wait_swap(200, cyc);
    chk("t4_swapped", 64'(cyc > 0), 64'd1);
    chk("t4_player", 64'(player === exp_player(3)), 64'd1);
    chk("t4_x", 64'(x), 64'd400);
    chk("t4_y", 64'(y), 64'd40);
    chk("t4_q_empty", 64'(exp_q.size()), 64'd0);
    step(2);
    chk("t4_no_second_load", 64'(busy), 64'd0);

    // Reset in the middle of a fetch
    trigger(4'd3, 11'd500, 11'd60, 1'b1, 1'b1);
    step(1);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() <= 35) break;
      step(1);
    end
    chk("t5_at_word40", 64'(exp_q.size()), 64'd35);
    rst = 1'b1;
    #1;
    chk("t5_req_async", 64'(mem_req), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_player_clr", 64'(player === '0), 64'd1);
    chk("t5_x_clr", 64'(x), 64'd0);
    exp_q.delete();
    #1;
    rst = 1'b0;
    trigger(4'd3, 11'd123, 11'd45, 1'b0, 1'b1);
    step(1);
    chk("t5_refetch", 64'(mem_req), 64'd1);
    wait_swap(200, cyc);
    chk("t5_swap_latency", 64'(cyc), 64'd76);
    chk("t5_player", 64'(player === exp_player(3)), 64'd1);
    chk("t5_x", 64'(x), 64'd123);

`ifdef T03_LOADER_TIMEOUT_EN
    // Stalled memory aborts the load
    ack_mode = 0;
    sv_player = player; sv_x = x; sv_y = y;
    trigger(4'd9, 11'd55, 11'd66, 1'b1, 1'b0);
    le = -1; saw = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      step(1);
      if (frame_swapped) saw = 1'b1;
      if (load_err) begin
        le = i;
        break;
      end
    end
    chk("t6_abort_cycle", 64'(le), 64'd256);
    step(1);
    chk("t6_err_single", 64'(load_err), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_no_swap", 64'(saw), 64'd0);
    chk("t6_player_kept", 64'(player === sv_player), 64'd1);
    chk("t6_x_kept", 64'(x), 64'(sv_x));
    chk("t6_y_kept", 64'(y), 64'(sv_y));
    ack_mode = 1;
`else
    le = 0;
    chk("load_err_low", 64'(load_err), 64'(le));
`endif

    chk("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
